// File: rtl/pixel_framebuffer.sv
// ---------------------------------------------------------------------------
// pixel_framebuffer
//
// Pixel-write sink for the sprite drawers plus a VGA scanout engine.
// Stores a 160x120 image of 3-bit {R,G,B} pixels. It scans the image out as
// 640x480@60 Hz VGA. Each stored pixel is shown as a 4x4 block on screen.
// After reset the whole buffer is filled with BG_COLOUR. Writes from the
// drawers are ignored until that fill is done.
//
// Ports
//   CLOCK_50     in   system clock, 50 MHz
//   resetn       in   asynchronous active-low reset
//   x[7:0]       in   write column, 0..159 accepted
//   y[6:0]       in   write row, 0..119 accepted
//   colour[2:0]  in   write colour {R,G,B}
//   plot         in   write strobe, sampled on every CLOCK_50 edge
//   busy         out  high while the background fill is running
//   VGA_CLK      out  25 MHz pixel clock (CLOCK_50 / 2)
//   VGA_HS       out  horizontal sync, active low
//   VGA_VS       out  vertical sync, active low
//   VGA_BLANK_N  out  low outside the visible area
//   VGA_R/G/B    out  colour bit replicated to 8 bits, 0 while blanked
// ---------------------------------------------------------------------------
module pixel_framebuffer #(
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic       busy,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  // Framebuffer geometry
  localparam logic [7:0]  FB_W       = 8'd160;
  localparam logic [6:0]  FB_H       = 7'd120;
  localparam int          FB_DEPTH   = 19200;
  localparam logic [14:0] LAST_ADDR  = 15'd19199;

  // 640x480@60 timing, in pixel clocks / lines
  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd752;  // first pixel after sync
  localparam logic [9:0] H_LAST       = 10'd799;
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd492;  // first line after sync
  localparam logic [9:0] V_LAST       = 10'd524;

  // -------------------------------------------------------------------------
  // Clear / run control
  // -------------------------------------------------------------------------
  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t      state_reg;
  logic [14:0] clr_addr_reg;
  logic        busy_reg;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= S_CLEAR;
      clr_addr_reg <= '0;
      busy_reg     <= 1'b1;
    end else begin
      case (state_reg)
        S_CLEAR: begin
          if (clr_addr_reg == LAST_ADDR) begin
            state_reg    <= S_RUN;
            busy_reg     <= 1'b0;
            clr_addr_reg <= '0;
          end else begin
            clr_addr_reg <= clr_addr_reg + 15'd1;
          end
        end
        S_RUN: begin
          busy_reg <= 1'b0;
        end
        default: begin
          state_reg    <= S_CLEAR;
          clr_addr_reg <= '0;
          busy_reg     <= 1'b1;
        end
      endcase
    end
  end

  assign busy = busy_reg;

  // -------------------------------------------------------------------------
  // Write port: the clear owns the port while it runs. In RUN, only
  // in-range coordinates are written, so a bad x can never wrap into the
  // next row.
  // -------------------------------------------------------------------------
  logic        plot_in_range;
  logic [14:0] plot_addr;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [2:0]  wr_data;

  assign plot_in_range = (x < FB_W) && (y < FB_H);
  // y*160 + x as shifts: 160 = 128 + 32
  assign plot_addr = ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clr_addr_reg;
    wr_data = BG_COLOUR;
    if (state_reg == S_CLEAR) begin
      wr_en = 1'b1;
    end else if (plot && plot_in_range) begin
      wr_en   = 1'b1;
      wr_addr = plot_addr;
      wr_data = colour;
    end
  end

  // -------------------------------------------------------------------------
  // Scan counters. pix_en_reg divides CLOCK_50 by two, and the counters
  // step on its high phase. Scanout runs in both CLEAR and RUN.
  // -------------------------------------------------------------------------
  logic       pix_en_reg;
  logic [9:0] h_cnt_reg;
  logic [9:0] v_cnt_reg;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      pix_en_reg <= 1'b0;
      h_cnt_reg  <= '0;
      v_cnt_reg  <= '0;
    end else begin
      pix_en_reg <= ~pix_en_reg;
      if (pix_en_reg) begin
        if (h_cnt_reg == H_LAST) begin
          h_cnt_reg <= '0;
          if (v_cnt_reg == V_LAST) begin
            v_cnt_reg <= '0;
          end else begin
            v_cnt_reg <= v_cnt_reg + 10'd1;
          end
        end else begin
          h_cnt_reg <= h_cnt_reg + 10'd1;
        end
      end
    end
  end

  assign VGA_CLK = pix_en_reg;

  logic        visible;
  logic        hs_n;
  logic        vs_n;
  logic [14:0] rd_addr;

  assign visible = (h_cnt_reg < H_VISIBLE) && (v_cnt_reg < V_VISIBLE);
  assign hs_n    = !((h_cnt_reg >= H_SYNC_START) && (h_cnt_reg < H_SYNC_END));
  assign vs_n    = !((v_cnt_reg >= V_SYNC_START) && (v_cnt_reg < V_SYNC_END));

  // Outside the visible area the row index can exceed the buffer. The
  // address is parked at 0 there so the read stays in bounds.
  assign rd_addr = visible
                 ? ({7'd0, h_cnt_reg[9:2]}
                    + ({8'd0, v_cnt_reg[8:2]} << 7)
                    + ({8'd0, v_cnt_reg[8:2]} << 5))
                 : 15'd0;

  // -------------------------------------------------------------------------
  // Simple dual-port RAM with registered read. A read and a write to the
  // same address on one edge return the old contents.
  // -------------------------------------------------------------------------
  logic [2:0] mem [0:FB_DEPTH-1];
  logic [2:0] rd_data_reg;

  always_ff @(posedge CLOCK_50) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_reg <= mem[rd_addr];
  end

  // -------------------------------------------------------------------------
  // Output stage. The read issued on the low phase of a pixel is ready by
  // the high phase. At that point the colour and the syncs computed from
  // the same counter values are latched together. Everything leaves one
  // pixel behind the counters, and colour and sync stay aligned.
  // -------------------------------------------------------------------------
  logic       hs_reg;
  logic       vs_reg;
  logic       blank_n_reg;
  logic [2:0] rgb_reg;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      hs_reg      <= 1'b1;
      vs_reg      <= 1'b1;
      blank_n_reg <= 1'b0;
      rgb_reg     <= 3'b000;
    end else if (pix_en_reg) begin
      hs_reg      <= hs_n;
      vs_reg      <= vs_n;
      blank_n_reg <= visible;
      rgb_reg     <= visible ? rd_data_reg : 3'b000;
    end
  end

  assign VGA_HS      = hs_reg;
  assign VGA_VS      = vs_reg;
  assign VGA_BLANK_N = blank_n_reg;

  // Each channel is its colour bit fanned out to the 8-bit DAC input
  logic [7:0] chan [0:2];

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign chan[gi] = {8{rgb_reg[gi]}};
  end

  assign VGA_R = chan[2];
  assign VGA_G = chan[1];
  assign VGA_B = chan[0];

endmodule

// File: doc/pixel_framebuffer.md
# pixel_framebuffer

Receiving end of the pixel-write interface driven by the sprite drawers (circle, note and drum blocks). Accepts one (x, y, colour, plot) write per CLOCK_50 cycle into a 160x120, 3-bit framebuffer and continuously scans that buffer out as 640x480@60 Hz VGA, with each stored pixel covering a 4x4 screen block. After reset, a clear sequence fills the buffer with a background colour before writes are accepted.

## Interface
- BG_COLOUR, 3'b000, colour written to every location during the clear sequence
- CLOCK_50  input  1  system clock, 50 MHz
- resetn  input  1  asynchronous, active-low reset
- x  input  8  write column, 0..159 valid
- y  input  7  write row, 0..119 valid
- colour  input  3  write colour {R,G,B}
- plot  input  1  write strobe, sampled on every CLOCK_50 edge
- busy  output  1  high while clearing; writes are ignored while high
- VGA_CLK  output  1  25 MHz pixel clock, CLOCK_50/2
- VGA_HS  output  1  horizontal sync, active low
- VGA_VS  output  1  vertical sync, active low
- VGA_BLANK_N  output  1  low outside the visible area
- VGA_R, VGA_G, VGA_B  output  8 each  each is its colour bit replicated 8 times, forced to 0 when blanked

## Operation
- Storage: 19200 x 3-bit simple dual-port RAM. Address = y*160 + x, computed as (y<<7)+(y<<5)+x, 15 bits.
- State machine, two states: CLEAR and RUN.
  - Reset enters CLEAR with clr_addr = 0 and busy = 1.
  - In CLEAR, each cycle writes BG_COLOUR at clr_addr and increments it.
  - After the write to address 19199, the FSM goes to RUN and busy drops.
  - RUN is held until reset. There is no other exit.
- Writes in RUN: plot=1 with x<160 and y<120 writes colour at that address on the same edge. Out-of-range coordinates are dropped silently; the address must not wrap. plot is ignored in CLEAR.
- Scanout runs in both states. Output is not suppressed during CLEAR.
  - pix_en toggles every CLOCK_50 cycle. VGA_CLK = pix_en register.
  - h_cnt 0..799 advances when pix_en=1 and wraps to 0. On that wrap, v_cnt 0..524 advances and wraps.
- Horizontal timing: visible 0..639; HS low for h_cnt 656..751.
- Vertical timing: visible 0..479; VS low for v_cnt 490..491.
- Read address = h_cnt[9:2] + 160*v_cnt[8:2], used only when visible.
- Read-during-write to the same address returns the old data. A new write shows on the next frame.

## Timing
- Reset (asynchronous) forces:
  - h_cnt=0, v_cnt=0, pix_en=0, state CLEAR, clr_addr=0, busy=1
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0, VGA_CLK=0
- Clear duration: busy stays high for exactly 19200 cycles after resetn rises. The first write is accepted on cycle 19200, counting from 0.
- Write latency: one edge. Data is in RAM after the edge on which plot was sampled.
- Scan pipeline:
  - RAM read is registered, giving 1 cycle of latency.
  - Colour, HS, VS and BLANK_N are registered together when pix_en=1.
  - All VGA outputs therefore lag h_cnt/v_cnt by exactly one pixel (2 CLOCK_50 cycles), so sync and colour stay aligned.
- Line period: 1600 CLOCK_50 cycles.
- Frame period: 840000 CLOCK_50 cycles.
- Reset mid-clear or mid-frame: everything returns to the reset values and the clear restarts from address 0. Buffer contents are undefined until the new clear completes.
- Simultaneous clear and plot: the clear write wins, and plot is discarded.

## Test plan
- Reset and clear: hold resetn=0 for 3 cycles, then release.
  - All outputs must hold their reset values while resetn=0.
  - busy must be high for exactly 19200 cycles.
  - With BG_COLOUR=3'b010, the first visible frame after clear must show only VGA_G=8'hFF, with R and B at 0.
- Single write: after clear, apply plot=1, x=10, y=5, colour=3'b101 for one cycle.
  - Next frame: screen columns 40..43 on rows 20..23 must read R=FF, G=00, B=FF.
  - All other pixels must stay at the background colour.
- Corner and range: write (159,119)=3'b111 and (160,0)=3'b100.
  - The bottom-right 4x4 block must be white.
  - Pixel (0,0) and every other pixel must be unchanged.
- Plot during clear: assert plot=1, x=0, y=0, colour=3'b111 at cycle 100 of the clear. Location (0,0) must read BG_COLOUR after the clear.
- Sync timing:
  - HS low for 192 CLOCK_50 cycles out of every 1600.
  - VS low for 3200 cycles out of every 840000.
  - BLANK_N high for 1280 cycles per visible line, and low for all of lines 480..524.
- Mid-frame reset: pull resetn low at v_cnt=200.
  - The outputs must go to their reset values asynchronously, before the next clock edge.
  - After release, busy must rise again and the earlier writes must be overwritten by BG_COLOUR.
